// File: rtl/quad_readout_sched_if.sv
// rtl/quad_readout_sched_if.sv - host-side control/readout bundle for quad_readout_sched
//
// Purpose: groups the host frame/readout/arming handshake of the quadrature
//          snapshot sequencer into one bundle.
// Signals:
//   frame_start  host -> dut  1-clk pulse: snapshot all channels, restart readout
//   rd_strobe    host -> dut  1-clk pulse: advance to next byte
//   arm_wr       host -> dut  1-clk pulse: apply arm_mask
//   arm_mask     host -> dut  NCHAN, 1 = arm that channel
//   rd_data      dut -> host  8, current readout byte
//   index_armed  dut -> host  NCHAN, channel waiting for index pulse
//   frame_busy   dut -> host  1 while bytes remain in the frame
//   overrun      dut -> host  sticky strobe-after-end flag
interface quad_readout_sched_if #(
   parameter int NCHAN = 4
);
   logic             frame_start;
   logic             rd_strobe;
   logic             arm_wr;
   logic [NCHAN-1:0] arm_mask;
   logic [7:0]       rd_data;
   logic [NCHAN-1:0] index_armed;
   logic             frame_busy;
   logic             overrun;

   modport master (
      output frame_start, rd_strobe, arm_wr, arm_mask,
      input  rd_data, index_armed, frame_busy, overrun
   );

   modport slave (
      input  frame_start, rd_strobe, arm_wr, arm_mask,
      output rd_data, index_armed, frame_busy, overrun
   );
endinterface

// File: rtl/quad_readout_sched.sv
// rtl/quad_readout_sched.sv - coherent snapshot and byte-serial readout of quadrature channels
//
// Purpose: on frame_start latches every channel's live count, index-latched count
//          and {seen, armed} flags in one clock, then serializes 4 bytes per channel,
//          one byte per rd_strobe. Also owns per-channel index arming with a sticky
//          "seen" flag that is reported in the following frame.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   c_in         NCHAN*W live counts, channel k at [k*W +: W]
//   i_in         NCHAN*W index-latched counts, same packing
//   index_pulse  NCHAN qualified index pulses
//   bus          slave side of quad_readout_sched_if (frame/readout/arming)
// Byte layout per channel k: b0 = c[7:0], b1 = {seen, armed, c[W-1:8] zero-padded},
//                            b2 = i[7:0], b3 = {2'b00, i[W-1:8] zero-padded}.
module quad_readout_sched #(
   parameter int NCHAN = 4,
   parameter int W     = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCHAN*W-1:0]   c_in,
   input  logic [NCHAN*W-1:0]   i_in,
   input  logic [NCHAN-1:0]     index_pulse,
   quad_readout_sched_if.slave  bus
);
   localparam int NBYTES = 4 * NCHAN;
   localparam int PW     = $clog2(NBYTES);
   localparam int CW     = PW - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic                 overrun_q, overrun_d;
   logic [NCHAN-1:0]     armed_q, armed_d;
   logic [NCHAN-1:0]     seen_q, seen_d;
   logic [NCHAN*W-1:0]   snap_c_q, snap_c_d;
   logic [NCHAN*W-1:0]   snap_i_q, snap_i_d;
   logic [2*NCHAN-1:0]   snap_f_q, snap_f_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic [13:0]          cx, ix;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      overrun_d = overrun_q;
      armed_d   = armed_q;
      seen_d    = seen_q;
      snap_c_d  = snap_c_q;
      snap_i_d  = snap_i_q;
      snap_f_d  = snap_f_q;
      rd_data_d = 8'h00;
      cx        = '0;
      ix        = '0;

      // frame_start outranks a coincident strobe: the strobe is simply dropped.
      if (bus.frame_start) begin
         state_d   = ST_SHIFT;
         ptr_d     = '0;
         overrun_d = 1'b0;
         snap_c_d  = c_in;
         snap_i_d  = i_in;
         for (int k = 0; k < NCHAN; k++) begin
            snap_f_d[2*k +: 2] = {seen_q[k], armed_q[k]};
         end
         seen_d = '0;
      end else if (bus.rd_strobe) begin
         case (state_q)
            ST_SHIFT: begin
               if (ptr_q == PW'(NBYTES - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  ptr_d = ptr_q + PW'(1);
               end
            end
            ST_DONE:  overrun_d = 1'b1;
            default:  ;
         endcase
      end

      // Arming is evaluated after the snapshot clear so that an index event in the
      // snapshot cycle sets seen for the next frame instead of being lost. An arm
      // write beats a same-cycle index pulse and leaves seen untouched.
      for (int k = 0; k < NCHAN; k++) begin
         if (bus.arm_wr && bus.arm_mask[k]) begin
            armed_d[k] = 1'b1;
         end else if (index_pulse[k] && armed_q[k]) begin
            armed_d[k] = 1'b0;
            seen_d[k]  = 1'b1;
         end
      end

      // rd_data is registered from next-state values so byte 0 appears the
      // cycle right after frame_start and each following byte right after its strobe.
      if (state_d == ST_SHIFT) begin
         for (int k = 0; k < NCHAN; k++) begin
            if (ptr_d[PW-1:2] == CW'(k)) begin
               cx = 14'(snap_c_d[k*W +: W]);
               ix = 14'(snap_i_d[k*W +: W]);
               case (ptr_d[1:0])
                  2'd0: rd_data_d = cx[7:0];
                  2'd1: rd_data_d = {snap_f_d[2*k+1], snap_f_d[2*k], cx[13:8]};
                  2'd2: rd_data_d = ix[7:0];
                  2'd3: rd_data_d = {2'b00, ix[13:8]};
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         overrun_q <= 1'b0;
         armed_q   <= '0;
         seen_q    <= '0;
         snap_c_q  <= '0;
         snap_i_q  <= '0;
         snap_f_q  <= '0;
         rd_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         overrun_q <= overrun_d;
         armed_q   <= armed_d;
         seen_q    <= seen_d;
         snap_c_q  <= snap_c_d;
         snap_i_q  <= snap_i_d;
         snap_f_q  <= snap_f_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.index_armed = armed_q;
   assign bus.frame_busy  = (state_q == ST_SHIFT);
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_quad_readout_sched.sv
// tb/tb_quad_readout_sched.sv - directed vector bench for quad_readout_sched
module tb_quad_readout_sched;
   localparam int NCHAN = 4;
   localparam int W     = 14;

   localparam logic [NCHAN*W-1:0] C0 = {14'h0001, 14'h3FFF, 14'h2345, 14'h1234};
   localparam logic [NCHAN*W-1:0] I0 = {14'h2A5A, 14'h0000, 14'h1111, 14'h0ABC};
   localparam logic [NCHAN*W-1:0] C1 = {4{14'h2B1E}};
   localparam logic [NCHAN*W-1:0] I1 = {4{14'h0D07}};

   logic               clk;
   logic               rst;
   logic [NCHAN*W-1:0] c_in;
   logic [NCHAN*W-1:0] i_in;
   logic [NCHAN-1:0]   index_pulse;

   quad_readout_sched_if #(.NCHAN(NCHAN)) bus ();

   quad_readout_sched #(.NCHAN(NCHAN), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .c_in        (c_in),
      .i_in        (i_in),
      .index_pulse (index_pulse),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic       fs, st, aw;
      logic [3:0] am, ip;
      logic       cs;
      logic [7:0] rd;
      logic       busy, ov;
      logic [3:0] arm;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic fs, st, aw, input logic [3:0] am, ip,
                      input logic cs, input logic [7:0] rd, input logic busy, ov,
                      input logic [3:0] arm);
      vec_t v;
      v.nm = nm; v.fs = fs; v.st = st; v.aw = aw; v.am = am; v.ip = ip; v.cs = cs;
      v.rd = rd; v.busy = busy; v.ov = ov; v.arm = arm;
      vecs.push_back(v);
   endtask

   task automatic step(input logic fs, st, aw, input logic [3:0] am, ip);
      bus.frame_start = fs;
      bus.rd_strobe   = st;
      bus.arm_wr      = aw;
      bus.arm_mask    = am;
      index_pulse     = ip;
      @(posedge clk);
      #1;
      bus.frame_start = 1'b0;
      bus.rd_strobe   = 1'b0;
      bus.arm_wr      = 1'b0;
      bus.arm_mask    = '0;
      index_pulse     = '0;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 4'h0, 4'h0);
   endtask

   logic [7:0] exp_seq [15];

   initial begin
      rst             = 1'b1;
      c_in            = C0;
      i_in            = I0;
      index_pulse     = '0;
      bus.frame_start = 1'b0;
      bus.rd_strobe   = 1'b0;
      bus.arm_wr      = 1'b0;
      bus.arm_mask    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset rd_data", 32'(bus.rd_data), 32'h00);
      check("reset busy", 32'(bus.frame_busy), 32'h0);
      check("reset overrun", 32'(bus.overrun), 32'h0);
      check("reset armed", 32'(bus.index_armed), 32'h0);
      rst = 1'b0;

      exp_seq = '{8'h12, 8'hBC, 8'h0A, 8'h45, 8'h23, 8'h11, 8'h11, 8'hFF,
                  8'h3F, 8'h00, 8'h00, 8'h01, 8'h00, 8'h5A, 8'h2A};

      //   name              fs st aw  am    ip   cs  rd     busy ov arm
      add("idle strobe",     0, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 4'h0);
      add("frame0 byte0",    1, 0, 0, 4'h0, 4'h0, 0, 8'h34, 1, 0, 4'h0);
      // c_in/i_in switch to the alternate set after the snapshot
      for (int b = 0; b < 15; b++)
         add($sformatf("frame0 byte%0d", b + 1), 0, 1, 0, 4'h0, 4'h0, 1, exp_seq[b], 1, 0, 4'h0);
      add("last strobe",     0, 1, 0, 4'h0, 4'h0, 1, 8'h00, 0, 0, 4'h0);
      add("extra strobe",    0, 1, 0, 4'h0, 4'h0, 1, 8'h00, 0, 1, 4'h0);
      add("overrun sticky",  0, 0, 0, 4'h0, 4'h0, 1, 8'h00, 0, 1, 4'h0);
      add("fs clears ov",    1, 0, 0, 4'h0, 4'h0, 1, 8'h1E, 1, 0, 4'h0);
      add("fs+strobe",       1, 1, 0, 4'h0, 4'h0, 1, 8'h1E, 1, 0, 4'h0);
      add("alt b1",          0, 1, 0, 4'h0, 4'h0, 1, 8'h2B, 1, 0, 4'h0);
      add("alt b2",          0, 1, 0, 4'h0, 4'h0, 1, 8'h07, 1, 0, 4'h0);
      add("alt b3",          0, 1, 0, 4'h0, 4'h0, 1, 8'h0D, 1, 0, 4'h0);
      add("arm 0101",        0, 0, 1, 4'h5, 4'h0, 1, 8'h0D, 1, 0, 4'h5);
      add("index 0011",      0, 0, 0, 4'h0, 4'h3, 1, 8'h0D, 1, 0, 4'h4);
      add("arm+index ch2",   0, 0, 1, 4'h4, 4'h4, 1, 8'h0D, 1, 0, 4'h4);
      add("flags frame b0",  1, 0, 0, 4'h0, 4'h0, 1, 8'h1E, 1, 0, 4'h4);
      add("flags ch0 b1",    0, 1, 0, 4'h0, 4'h0, 1, 8'hAB, 1, 0, 4'h4);

      foreach (vecs[n]) begin
         step(vecs[n].fs, vecs[n].st, vecs[n].aw, vecs[n].am, vecs[n].ip);
         check({vecs[n].nm, " rd_data"}, 32'(bus.rd_data), 32'(vecs[n].rd));
         check({vecs[n].nm, " busy"}, 32'(bus.frame_busy), 32'(vecs[n].busy));
         check({vecs[n].nm, " overrun"}, 32'(bus.overrun), 32'(vecs[n].ov));
         check({vecs[n].nm, " armed"}, 32'(bus.index_armed), 32'(vecs[n].arm));
         c_in = vecs[n].cs ? C1 : C0;
         i_in = vecs[n].cs ? I1 : I0;
         if (n == 1) begin
            c_in = C1;
            i_in = I1;
         end
      end

      // Reset mid-frame at byte 5, then a clean frame
      strobes(4);
      check("pre-reset byte5", 32'(bus.rd_data), 32'h2B);
      rst = 1'b1;
      step(0, 0, 0, 4'h0, 4'h0);
      rst = 1'b0;
      check("mid reset rd_data", 32'(bus.rd_data), 32'h00);
      check("mid reset busy", 32'(bus.frame_busy), 32'h0);
      check("mid reset armed", 32'(bus.index_armed), 32'h0);
      step(1, 0, 0, 4'h0, 4'h0);
      check("post reset byte0", 32'(bus.rd_data), 32'h1E);
      check("post reset busy", 32'(bus.frame_busy), 32'h1);
      strobes(1);
      check("post reset flags", 32'(bus.rd_data), 32'h2B);

      // Arm ch1, index 5 clocks later, seen reported once
      step(0, 0, 1, 4'h2, 4'h0);
      for (int i = 0; i < 5; i++) begin
         check("ch1 armed wait", 32'(bus.index_armed), 32'h2);
         step(0, 0, 0, 4'h0, 4'h0);
      end
      step(0, 0, 0, 4'h0, 4'h2);
      check("ch1 disarmed", 32'(bus.index_armed), 32'h0);
      step(1, 0, 0, 4'h0, 4'h0);
      strobes(5);
      check("ch1 seen frame", 32'(bus.rd_data), 32'hAB);
      step(1, 0, 0, 4'h0, 4'h0);
      strobes(5);
      check("ch1 seen cleared", 32'(bus.rd_data), 32'h2B);

      // Snapshot coincident with index on armed ch0
      step(0, 0, 1, 4'h1, 4'h0);
      check("ch0 armed", 32'(bus.index_armed), 32'h1);
      step(1, 0, 0, 4'h0, 4'h1);
      check("ch0 disarmed at fs", 32'(bus.index_armed), 32'h0);
      strobes(1);
      check("ch0 pre-event flags", 32'(bus.rd_data), 32'h6B);
      step(1, 0, 0, 4'h0, 4'h0);
      strobes(1);
      check("ch0 seen next frame", 32'(bus.rd_data), 32'hAB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
